pulse_pattern_gen: RTL
======================

Name: pulse_pattern_gen

Overview:
Parametrised tick prescaler plus burst/hold pattern sequencer. It generalises the fixed divide-by-400001 clock and the 9-toggle / 20-high / 1-gap pattern into a configurable block. The block is fully synchronous to one clock and uses a tick enable, not a derived clock. It adds one-shot and continuous modes, enable gating, a done strobe and phase visibility. It drives slow indicator/test-pattern pins from the fabric clock domain.

Parameters:
DIV, 400001, prescaler period in clk cycles (>=2)
LOW_TICKS, 9, ticks spent in TOGGLE phase (>=1)
HIGH_TICKS, 20, ticks spent in HOLD phase (>=1)
GAP_TICKS, 1, ticks spent in GAP phase (>=1)
Counter widths derived via $clog2; any parameter outside range is an elaboration error.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  global enable; 0 freezes prescaler and sequencer
start  in  1  one-shot request, sampled while IDLE
continuous  in  1  1 = repeat pattern indefinitely
tick  out  1  one-clk pulse every DIV enabled cycles
clk_div  out  1  square wave: 0 for prescaler count < DIV/2 (integer), else 1
tog  out  1  toggles once per tick during TOGGLE
rr  out  1  high exactly while phase is HOLD
busy  out  1  high whenever phase != IDLE
done  out  1  one-clk pulse on one-shot completion
phase  out  2  0=IDLE 1=TOGGLE 2=HOLD 3=GAP

Behaviour:
- Reset: clk is already decided as the single clock; rst_n is synchronous and active-low. rst_n=0 at a clk edge sets: prescaler count=0, phase count=0, phase=IDLE, tick=0, clk_div=0, tog=1, rr=0, busy=0, done=0, start_pending=0. Mid-operation reset aborts immediately with no done pulse.
- Prescaler: when en=1, count increments and wraps DIV-1 -> 0. tick is combinational and high in the cycle count==DIV-1. First tick after reset occurs in the DIV-th enabled cycle. en=0 holds count, forces tick=0 and holds all sequencer state.
- start: a 1 while IDLE and en=1 sets start_pending. start while busy is ignored (not queued).
- All sequencer transitions happen only on clk edges where tick=1.
  - IDLE: if start_pending or continuous, go to TOGGLE, phase count=0, clear start_pending. tog is unchanged on entry.
  - TOGGLE: on each tick, tog<=~tog. After the LOW_TICKS-th toggle, go to HOLD.
  - HOLD: rr=1 (registered from phase). Leave for GAP after HIGH_TICKS ticks.
  - GAP: after GAP_TICKS ticks, if continuous=1 go to TOGGLE; else go to IDLE and pulse done for exactly one clk (the edge entering IDLE).
- Period per pattern = LOW_TICKS+HIGH_TICKS+GAP_TICKS ticks (default 30).
- continuous is sampled only at the GAP exit and in IDLE. Deasserting it mid-pattern completes the current pattern, then goes to IDLE with done.
- tog is not reset between patterns. It carries parity; with odd LOW_TICKS it alternates start level per pattern.
- start and continuous are simultaneous in IDLE: a single entry; start_pending is cleared.
- busy, rr, phase, done and clk_div are registered; tick is the only combinational output.

Test Plan:
- Params DIV=4,LOW=3,HIGH=5,GAP=1; rst_n released, en=1 -> tick high at enabled cycles 3,7,11,...; clk_div 0,0,1,1 repeating.
- One-shot: start pulse at cycle 1 -> TOGGLE from first tick. tog goes 1->0->1->0 over 3 ticks. rr high for 5 ticks (20 clks). GAP 1 tick, then done pulse once, busy=0, phase=0.
- Continuous=1 held: pattern repeats every 9 ticks (36 clks). done never pulses. Drop continuous during HOLD -> pattern finishes, single done.
- en=0 for 10 cycles mid-HOLD -> all outputs and counts frozen. Resume yields HOLD total of exactly 5 ticks.
- rst_n=0 one cycle during TOGGLE -> next cycle phase=0, tog=1, rr=0, no done. Next tick at 4th enabled cycle after release.
- start asserted while busy -> ignored. After completion, no second pattern runs without a fresh start.

Source files
------------

// File: rtl/pulse_pattern_gen_if.sv
// Control and status bundle of the tick prescaler / pattern sequencer.
// The master drives the controls; the slave (the block itself) drives status.
interface pulse_pattern_gen_if;
  logic       en;
  logic       start;
  logic       continuous;
  logic       tick;
  logic       clk_div;
  logic       tog;
  logic       rr;
  logic       busy;
  logic       done;
  logic [1:0] phase;

  modport master (
    output en, start, continuous,
    input  tick, clk_div, tog, rr, busy, done, phase
  );

  modport slave (
    input  en, start, continuous,
    output tick, clk_div, tog, rr, busy, done, phase
  );
endinterface

// File: rtl/pulse_pattern_gen.sv
// Tick prescaler plus TOGGLE/HOLD/GAP pattern sequencer, single clock domain.
// The sequencer advances only on prescaler ticks; tick is the one combinational output.
module pulse_pattern_gen #(
  parameter int DIV        = 400001,
  parameter int LOW_TICKS  = 9,
  parameter int HIGH_TICKS = 20,
  parameter int GAP_TICKS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  pulse_pattern_gen_if.slave bus
);

  localparam int CW   = $clog2(DIV);
  localparam int MAXT = (LOW_TICKS > HIGH_TICKS)
                      ? ((LOW_TICKS  > GAP_TICKS) ? LOW_TICKS  : GAP_TICKS)
                      : ((HIGH_TICKS > GAP_TICKS) ? HIGH_TICKS : GAP_TICKS);
  localparam int PW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
  localparam logic [PW-1:0] LOW_LAST  = PW'(LOW_TICKS - 1);
  localparam logic [PW-1:0] HIGH_LAST = PW'(HIGH_TICKS - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_TICKS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("pulse_pattern_gen: DIV must be >= 2");
  end
  if (LOW_TICKS < 1) begin : g_bad_low
    $error("pulse_pattern_gen: LOW_TICKS must be >= 1");
  end
  if (HIGH_TICKS < 1) begin : g_bad_high
    $error("pulse_pattern_gen: HIGH_TICKS must be >= 1");
  end
  if (GAP_TICKS < 1) begin : g_bad_gap
    $error("pulse_pattern_gen: GAP_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TOGGLE = 2'd1,
    HOLD   = 2'd2,
    GAP    = 2'd3
  } phase_t;

  // Prescaler
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_clk_div;
  logic          w_tick;

  assign w_tick = bus.en && (r_cnt == CNT_LAST);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (bus.en) w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
  end

  // clk_div is registered from the next count so it always matches the current count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_clk_div <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_clk_div <= (w_cnt_nxt >= CNT_HALF);
    end
  end

  // Sequencer
  phase_t        r_phase, w_phase_nxt;
  logic [PW-1:0] r_pcnt, w_pcnt_nxt;
  logic          r_tog, w_tog_nxt;
  logic          r_pend, w_pend_nxt;
  logic          w_done_nxt;
  logic          r_rr, r_busy, r_done;

  always_comb begin
    w_phase_nxt = r_phase;
    w_pcnt_nxt  = r_pcnt;
    w_tog_nxt   = r_tog;
    w_pend_nxt  = r_pend;
    w_done_nxt  = 1'b0;
    if (r_phase == IDLE && bus.en && bus.start) w_pend_nxt = 1'b1;
    if (w_tick) begin
      case (r_phase)
        IDLE: begin
          // a start coinciding with a continuous entry collapses into one run
          if (r_pend || bus.continuous) begin
            w_phase_nxt = TOGGLE;
            w_pcnt_nxt  = '0;
            w_pend_nxt  = 1'b0;
          end
        end
        TOGGLE: begin
          w_tog_nxt = ~r_tog;
          if (r_pcnt == LOW_LAST) begin
            w_phase_nxt = HOLD;
            w_pcnt_nxt  = '0;
          end else begin
            w_pcnt_nxt = r_pcnt + PW'(1);
          end
        end
        HOLD: begin
          if (r_pcnt == HIGH_LAST) begin
            w_phase_nxt = GAP;
            w_pcnt_nxt  = '0;
          end else begin
            w_pcnt_nxt = r_pcnt + PW'(1);
          end
        end
        GAP: begin
          if (r_pcnt == GAP_LAST) begin
            w_pcnt_nxt = '0;
            if (bus.continuous) begin
              w_phase_nxt = TOGGLE;
            end else begin
              w_phase_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_pcnt_nxt = r_pcnt + PW'(1);
          end
        end
        default: w_phase_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase <= IDLE;
      r_pcnt  <= '0;
      r_tog   <= 1'b1;
      r_pend  <= 1'b0;
      r_rr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_tog   <= w_tog_nxt;
      r_pend  <= w_pend_nxt;
      r_rr    <= (w_phase_nxt == HOLD);
      r_busy  <= (w_phase_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign bus.tick    = w_tick;
  assign bus.clk_div = r_clk_div;
  assign bus.tog     = r_tog;
  assign bus.rr      = r_rr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.phase   = r_phase;

endmodule
